// File: rtl/pwm_duty_sequencer_pkg.sv
// Shared types for the breathing-envelope duty sequencer: FSM state encodings
// and the full-scale duty helper.
package pwm_duty_sequencer_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_UP      = 3'd1,
    SEQ_HOLD_HI = 3'd2,
    SEQ_DOWN    = 3'd3,
    SEQ_HOLD_LO = 3'd4
  } seq_state_t;

  // All-ones value of a w-bit duty word (w <= 31).
  function automatic logic [31:0] duty_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_duty_sequencer_prescaler.sv
// Envelope tick generator: counts 0..presc while run is high, pulses tick on
// the terminal count; held cleared while run is low.
module duty_tick_prescaler #(
  parameter int PRESC_W = 20
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               run,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt;

  always_ff @(posedge CLOCK_50) begin
    if (reset || !run) begin
      cnt <= '0;
    end else if (cnt == presc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PRESC_W'(1);
    end
  end

  assign tick = run && (cnt == presc);

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Breathing-envelope duty generator with a latest-wins mailbox towards the PWM stage.
// Optional perceptual curve stage enabled by defining PWM_DUTY_GAMMA_EN.
//
// state       | meaning
// SEQ_IDLE    | parked, lin=0, waiting for enable
// SEQ_UP      | lin ramps up by step per tick
// SEQ_HOLD_HI | lin at full scale for hold_ticks+1 ticks
// SEQ_DOWN    | lin ramps down by step per tick
// SEQ_HOLD_LO | lin at zero for hold_ticks+1 ticks, then UP or IDLE
module pwm_duty_sequencer
  import pwm_duty_sequencer_pkg::*;
#(
  parameter int DUTY_W  = 16,
  parameter int PRESC_W = 20,
  parameter int HOLD_W  = 8
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               enable,
  input  logic [PRESC_W-1:0] presc,
  input  logic [DUTY_W-1:0]  step,
  input  logic [HOLD_W-1:0]  hold_ticks,
  output logic [DUTY_W-1:0]  duty,
  output logic               duty_valid,
  input  logic               duty_ready,
  output logic [2:0]         state
);

  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(duty_max(DUTY_W));

  seq_state_t         state_q, state_d;
  logic [DUTY_W-1:0]  lin_q, lin_d;
  logic [HOLD_W-1:0]  hold_cnt, hold_d;
  logic [PRESC_W-1:0] presc_cfg;
  logic [DUTY_W-1:0]  step_cfg;
  logic [HOLD_W-1:0]  hold_cfg;
  logic               load_cfg;
  logic               lin_upd;
  logic               tick;
  logic [DUTY_W-1:0]  step_eff;
  logic [DUTY_W:0]    lin_sum;
  logic [DUTY_W-1:0]  new_val;
  logic               new_vld;

  duty_tick_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .run      (state_q != SEQ_IDLE),
    .presc    (presc_cfg),
    .tick     (tick)
  );

  assign step_eff = (step_cfg == '0) ? DUTY_W'(1) : step_cfg;
  assign lin_sum  = {1'b0, lin_q} + {1'b0, step_eff};

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= SEQ_IDLE;
      lin_q     <= '0;
      hold_cnt  <= '0;
      presc_cfg <= '0;
      step_cfg  <= '0;
      hold_cfg  <= '0;
      lin_upd   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lin_q    <= lin_d;
      hold_cnt <= hold_d;
      lin_upd  <= (lin_d != lin_q);
      if (load_cfg) begin
        presc_cfg <= presc;
        step_cfg  <= step;
        hold_cfg  <= hold_ticks;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    lin_d    = lin_q;
    hold_d   = hold_cnt;
    load_cfg = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        lin_d = '0;
        if (enable) begin
          state_d  = SEQ_UP;
          load_cfg = 1'b1;
        end
      end
      SEQ_UP: begin
        if (tick) begin
          if (!enable) begin
            state_d = SEQ_DOWN;
          end else if (lin_sum >= {1'b0, DUTY_MAX}) begin
            lin_d   = DUTY_MAX;
            hold_d  = '0;
            state_d = SEQ_HOLD_HI;
          end else begin
            lin_d = lin_sum[DUTY_W-1:0];
          end
        end
      end
      SEQ_HOLD_HI: begin
        if (tick) begin
          if (!enable || hold_cnt == hold_cfg) begin
            state_d = SEQ_DOWN;
          end else begin
            hold_d = hold_cnt + HOLD_W'(1);
          end
        end
      end
      SEQ_DOWN: begin
        if (tick) begin
          if (lin_q <= step_eff) begin
            lin_d   = '0;
            hold_d  = '0;
            state_d = SEQ_HOLD_LO;
          end else begin
            lin_d = lin_q - step_eff;
          end
        end
      end
      SEQ_HOLD_LO: begin
        if (tick) begin
          if (hold_cnt == hold_cfg) begin
            state_d = enable ? SEQ_UP : SEQ_IDLE;
          end else begin
            hold_d = hold_cnt + HOLD_W'(1);
          end
        end
      end
      default: begin
        state_d = SEQ_IDLE;
        lin_d   = '0;
      end
    endcase
  end

`ifdef PWM_DUTY_GAMMA_EN
  logic [2*DUTY_W-1:0] lin_sq;
  logic [DUTY_W-1:0]   gamma_q;
  logic                gamma_upd;

  // Squared curve: full scale lands one below DUTY_MAX.
  assign lin_sq = {{DUTY_W{1'b0}}, lin_q} * {{DUTY_W{1'b0}}, lin_q};

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      gamma_q   <= '0;
      gamma_upd <= 1'b0;
    end else begin
      gamma_q   <= DUTY_W'(lin_sq >> DUTY_W);
      gamma_upd <= lin_upd;
    end
  end

  assign new_val = gamma_q;
  assign new_vld = gamma_upd;
`else
  assign new_val = lin_q;
  assign new_vld = lin_upd;
`endif

  // Latest wins: a fresh value always overwrites, even if the old one was just taken.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      duty       <= '0;
      duty_valid <= 1'b0;
    end else if (new_vld) begin
      duty       <= new_val;
      duty_valid <= 1'b1;
    end else if (duty_valid && duty_ready) begin
      duty_valid <= 1'b0;
    end
  end

  assign state = state_q;

endmodule
